// File: rtl/gbf_bus_pkg.sv
// Shared types, defaults and the base-address helper for the GBF read-port scheduler.
package gbf_bus_pkg;

    localparam int unsigned DEF_MAX_BURST  = 16;
    localparam int unsigned DEF_ROW_STRIDE = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } ch_state_e;

    // Untruncated burst base; the caller cuts it down to the RAM address width.
    function automatic logic [31:0] gbf_base(
        input logic [31:0] i,
        input logic [31:0] k,
        input logic [31:0] len,
        input logic [31:0] stride
    );
        return i * stride + k * len;
    endfunction

endpackage

// File: rtl/gbf_rr_arbiter.sv
// Round-robin pick: first unmasked request at or after rr_ptr, wrapping around.
module gbf_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [SEL_W-1:0]   rr_ptr,
    output logic               any_req_c,
    output logic [SEL_W-1:0]   sel_c
);

    int unsigned       scan;
    logic [SEL_W-1:0]  scan_idx;

    always_comb begin
        any_req_c = 1'b0;
        sel_c     = '0;
        scan      = 0;
        scan_idx  = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            scan     = (32'(rr_ptr) + off) % NUM_REQ;
            scan_idx = SEL_W'(scan);
            if (!any_req_c && req[scan_idx] && !mask[scan_idx]) begin
                any_req_c = 1'b1;
                sel_c     = scan_idx;
            end
        end
    end

endmodule

// File: rtl/gbf_bus_sched.sv
// GBF read-port scheduler: NUM_CH independent channels, each a round-robin burst
// engine driving one RAM read port and a grant strobe aligned to the read data.
module gbf_bus_sched
    import gbf_bus_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST,
    parameter int unsigned ROW_STRIDE = DEF_ROW_STRIDE
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [$clog2(MAX_BURST+1)-1:0]     cfg_burst_len,
    input  logic [NUM_CH*NUM_REQ-1:0]          req,
    input  logic [NUM_CH*NUM_REQ*IDX_W-1:0]    idx_i,
    input  logic [NUM_CH*NUM_REQ*IDX_W-1:0]    idx_k,
    output logic [NUM_CH*NUM_REQ-1:0]          grant,
    output logic [NUM_CH*ADDR_W-1:0]           addr,
    output logic [NUM_CH-1:0]                  addr_valid,
    output logic [NUM_CH-1:0]                  busy
);

    localparam int unsigned LEN_W = $clog2(MAX_BURST + 1);
    localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_e          state_q, state_d;
        logic [SEL_W-1:0]   sel_q, sel_d, rr_ptr_q, rr_ptr_d;
        logic [SEL_W-1:0]   next_ptr, arb_ptr, win_sel;
        logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d, new_len;
        logic [ADDR_W-1:0]  base_q, base_d, addr_q, addr_d, new_base;
        logic               av_q, av_d, busy_q, busy_d;
        logic [NUM_REQ-1:0] grant_q, grant_d, ch_req, arb_mask;
        logic               any_req, last_beat, load;
        logic [IDX_W-1:0]   ch_i [NUM_REQ];
        logic [IDX_W-1:0]   ch_k [NUM_REQ];

        for (genvar r = 0; r < NUM_REQ; r++) begin : g_idx
            assign ch_i[r] = idx_i[(c*NUM_REQ + r)*IDX_W +: IDX_W];
            assign ch_k[r] = idx_k[(c*NUM_REQ + r)*IDX_W +: IDX_W];
        end

        assign ch_req    = req[c*NUM_REQ +: NUM_REQ];
        assign last_beat = (cnt_q == len_q - LEN_W'(1));
        assign next_ptr  = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + SEL_W'(1);
        // On the last beat the pointer has already moved past sel and sel itself is excluded.
        assign arb_ptr   = (state_q == BURST) ? next_ptr : rr_ptr_q;
        assign arb_mask  = (state_q == BURST) ? (NUM_REQ'(1) << sel_q) : '0;
        assign new_len   = (cfg_burst_len == '0) ? LEN_W'(1) : cfg_burst_len;
        assign new_base  = ADDR_W'(gbf_base(32'(ch_i[win_sel]), 32'(ch_k[win_sel]),
                                            32'(new_len), ROW_STRIDE));

        gbf_rr_arbiter #(
            .NUM_REQ (NUM_REQ),
            .SEL_W   (SEL_W)
        ) u_arb (
            .req       (ch_req),
            .mask      (arb_mask),
            .rr_ptr    (arb_ptr),
            .any_req_c (any_req),
            .sel_c     (win_sel)
        );

        always_comb begin
            state_d  = state_q;
            sel_d    = sel_q;
            len_d    = len_q;
            base_d   = base_q;
            cnt_d    = cnt_q;
            rr_ptr_d = rr_ptr_q;
            addr_d   = '0;
            av_d     = 1'b0;
            busy_d   = 1'b0;
            load     = 1'b0;
            // Grant trails the address by one cycle to line up with RAM read data.
            grant_d  = av_q ? (NUM_REQ'(1) << sel_q) : '0;

            case (state_q)
                IDLE: begin
                    load = any_req;
                end
                BURST: begin
                    if (last_beat) begin
                        rr_ptr_d = next_ptr;
                        load     = any_req;
                        if (!any_req) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d  = cnt_q + LEN_W'(1);
                        addr_d = base_q + ADDR_W'(cnt_d);
                        av_d   = 1'b1;
                        busy_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (load) begin
                state_d = BURST;
                sel_d   = win_sel;
                len_d   = new_len;
                base_d  = new_base;
                cnt_d   = '0;
                addr_d  = new_base;
                av_d    = 1'b1;
                busy_d  = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q  <= IDLE;
                sel_q    <= '0;
                rr_ptr_q <= '0;
                len_q    <= '0;
                cnt_q    <= '0;
                base_q   <= '0;
                addr_q   <= '0;
                av_q     <= 1'b0;
                busy_q   <= 1'b0;
                grant_q  <= '0;
            end else begin
                state_q  <= state_d;
                sel_q    <= sel_d;
                rr_ptr_q <= rr_ptr_d;
                len_q    <= len_d;
                cnt_q    <= cnt_d;
                base_q   <= base_d;
                addr_q   <= addr_d;
                av_q     <= av_d;
                busy_q   <= busy_d;
                grant_q  <= grant_d;
            end
        end

        assign grant[c*NUM_REQ +: NUM_REQ] = grant_q;
        assign addr[c*ADDR_W +: ADDR_W]    = addr_q;
        assign addr_valid[c]               = av_q;
        assign busy[c]                     = busy_q;
    end

endmodule

// File: tb/tb_gbf_bus_sched.sv
// Bench for gbf_bus_sched: directed scenarios plus random traffic against a
// per-channel transaction-level reference model.
module tb_gbf_bus_sched;

    localparam int NUM_CH     = 4;
    localparam int NUM_REQ    = 4;
    localparam int IDX_W      = 8;
    localparam int ADDR_W     = 5;
    localparam int LEN_W      = 5;
    localparam int ROW_STRIDE = 12;
    localparam int ADDR_MOD   = 32;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [LEN_W-1:0]            cfg_burst_len;
    logic [NUM_CH*NUM_REQ-1:0]   req;
    logic [NUM_CH*NUM_REQ*IDX_W-1:0] idx_i, idx_k;
    logic [NUM_CH*NUM_REQ-1:0]   grant;
    logic [NUM_CH*ADDR_W-1:0]    addr;
    logic [NUM_CH-1:0]           addr_valid, busy;

    int n_cmp, n_err;

    // Model: current burst per channel plus the one-cycle-delayed grant owner.
    int m_busy [NUM_CH], m_sel [NUM_CH], m_len [NUM_CH], m_base [NUM_CH];
    int m_beat [NUM_CH], m_ptr [NUM_CH], m_gsel [NUM_CH];
    int n_busy [NUM_CH], n_sel [NUM_CH], n_len [NUM_CH], n_base [NUM_CH];
    int n_beat [NUM_CH], n_ptr [NUM_CH], n_gsel [NUM_CH];

    always #5 clk = ~clk;

    gbf_bus_sched dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_burst_len (cfg_burst_len),
        .req           (req),
        .idx_i         (idx_i),
        .idx_k         (idx_k),
        .grant         (grant),
        .addr          (addr),
        .addr_valid    (addr_valid),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_busy[c] = 0; m_sel[c] = 0; m_len[c] = 0; m_base[c] = 0;
            m_beat[c] = 0; m_ptr[c] = 0; m_gsel[c] = -1;
        end
    endtask

    function automatic int pick(int c, int ptr, int skip);
        for (int o = 0; o < NUM_REQ; o++) begin
            int r;
            r = (ptr + o) % NUM_REQ;
            if (r != skip && req[c*NUM_REQ + r]) return r;
        end
        return -1;
    endfunction

    task automatic decide(int c, int ptr, int skip);
        int w, eff, ii, kk;
        w = pick(c, ptr, skip);
        if (w < 0) begin
            n_busy[c] = 0;
            n_beat[c] = 0;
        end else begin
            eff = (cfg_burst_len == 0) ? 1 : int'(cfg_burst_len);
            ii  = int'(idx_i[(c*NUM_REQ + w)*IDX_W +: IDX_W]);
            kk  = int'(idx_k[(c*NUM_REQ + w)*IDX_W +: IDX_W]);
            n_busy[c] = 1;
            n_sel[c]  = w;
            n_len[c]  = eff;
            n_base[c] = (ii*ROW_STRIDE + kk*eff) % ADDR_MOD;
            n_beat[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            n_busy[c] = m_busy[c]; n_sel[c] = m_sel[c]; n_len[c] = m_len[c];
            n_base[c] = m_base[c]; n_beat[c] = m_beat[c]; n_ptr[c] = m_ptr[c];
            n_gsel[c] = (m_busy[c] != 0) ? m_sel[c] : -1;
            if (m_busy[c] == 0) begin
                decide(c, m_ptr[c], -1);
            end else if (m_beat[c] == m_len[c] - 1) begin
                n_ptr[c] = (m_sel[c] + 1) % NUM_REQ;
                decide(c, n_ptr[c], m_sel[c]);
            end else begin
                n_beat[c] = m_beat[c] + 1;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            m_busy[c] = n_busy[c]; m_sel[c] = n_sel[c]; m_len[c] = n_len[c];
            m_base[c] = n_base[c]; m_beat[c] = n_beat[c]; m_ptr[c] = n_ptr[c];
            m_gsel[c] = n_gsel[c];
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("busy%0d", c), 32'(busy[c]), 32'(m_busy[c]));
            chk($sformatf("valid%0d", c), 32'(addr_valid[c]), 32'(m_busy[c]));
            chk($sformatf("grant%0d", c), 32'(grant[c*NUM_REQ +: NUM_REQ]),
                (m_gsel[c] >= 0) ? (32'd1 << m_gsel[c]) : 32'd0);
            if (m_busy[c] != 0)
                chk($sformatf("addr%0d", c), 32'(addr[c*ADDR_W +: ADDR_W]),
                    32'((m_base[c] + m_beat[c]) % ADDR_MOD));
        end
    endtask

    // Inputs for the current cycle are already driven; the model decides from them.
    task automatic step_cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // A served requester lets go of req once its final address beat is on the bus.
    task automatic auto_drop();
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < NUM_REQ; r++)
                if (req[c*NUM_REQ + r] && m_busy[c] != 0 && m_sel[c] == r &&
                    m_beat[c] == m_len[c] - 1)
                    req[c*NUM_REQ + r] = 1'b0;
    endtask

    task automatic set_idx(int c, int r, int i, int k);
        idx_i[(c*NUM_REQ + r)*IDX_W +: IDX_W] = IDX_W'(i);
        idx_k[(c*NUM_REQ + r)*IDX_W +: IDX_W] = IDX_W'(k);
    endtask

    int rr_exp [6] = '{0, 1, 1, 8, 8, 1};
    int beats [NUM_CH];
    int exp_beats [NUM_CH] = '{1, 3, 5, 16};
    int cnt;

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; cfg_burst_len = '0; req = '0; idx_i = '0; idx_k = '0;
        model_reset();
        #1 rst = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_valid", 32'(addr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        compare_all();
        rst = 1'b1;

        // Single burst: ch0 requester 2, i=1 k=0 len=4 -> addresses 12..15.
        cfg_burst_len = 5'd4;
        set_idx(0, 2, 1, 0);
        req[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step_cycle();
            if (k <= 4) chk("p1_addr", 32'(addr[4:0]), 32'(11 + k));
            chk("p1_busy", 32'(busy[0]), (k <= 4) ? 32'd1 : 32'd0);
            chk("p1_grant", 32'(grant[3:0]), (k >= 2 && k <= 5) ? 32'd4 : 32'd0);
            auto_drop();
        end

        // Round robin on ch1 with requesters 0 and 3 held, len 2.
        cfg_burst_len = 5'd2;
        req[4] = 1'b1;
        req[7] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step_cycle();
            chk("rr_grant", 32'(grant[7:4]), 32'(rr_exp[k]));
            chk("rr_valid", 32'(addr_valid[1]), 32'd1);
        end
        req[7:4] = '0;
        for (int k = 0; k < 5; k++) step_cycle();

        // Address wrap on ch2: base 0 with len 8, then base 30 with len 6.
        cfg_burst_len = 5'd8;
        set_idx(2, 0, 2, 1);
        req[8] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step_cycle();
            chk("wrap0_addr", 32'(addr[14:10]), 32'(k - 1));
            auto_drop();
        end
        for (int k = 0; k < 2; k++) step_cycle();
        cfg_burst_len = 5'd6;
        req[8] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step_cycle();
            chk("wrap30_addr", 32'(addr[14:10]), 32'((29 + k) % ADDR_MOD));
            auto_drop();
        end
        for (int k = 0; k < 3; k++) step_cycle();

        // Zero length acts as one beat; a mid-burst cfg change does not shorten the burst.
        cfg_burst_len = 5'd0;
        req[13] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step_cycle();
            cnt += int'(busy[3]);
            auto_drop();
        end
        chk("len0_beats", 32'(cnt), 32'd1);
        cfg_burst_len = 5'd5;
        req[13] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 9; k++) begin
            step_cycle();
            if (k == 0) cfg_burst_len = 5'd1;
            cnt += int'(busy[3]);
            auto_drop();
        end
        chk("cfgchg_beats", 32'(cnt), 32'd5);

        // Asynchronous reset in the middle of a burst.
        cfg_burst_len = 5'd4;
        set_idx(0, 0, 0, 3);
        req[0] = 1'b1;
        step_cycle();
        step_cycle();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(addr_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        model_reset();
        req = '0;
        @(posedge clk); #1;
        compare_all();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) step_cycle();

        // All four channels busy at once with lengths 1, 3, 5, 16.
        for (int c = 0; c < NUM_CH; c++) beats[c] = 0;
        for (int k = 0; k < 29; k++) begin
            if (k < NUM_CH) begin
                cfg_burst_len = LEN_W'(exp_beats[k]);
                set_idx(k, 3 - k, k + 1, k);
                req[k*NUM_REQ + 3 - k] = 1'b1;
            end
            step_cycle();
            for (int c = 0; c < NUM_CH; c++) begin
                beats[c] += int'(busy[c]);
                chk("onehot", 32'($onehot0(grant[c*NUM_REQ +: NUM_REQ])), 32'd1);
            end
            auto_drop();
        end
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("multi_beats%0d", c), 32'(beats[c]), 32'(exp_beats[c]));

        // Random traffic on every channel.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) cfg_burst_len = LEN_W'($urandom_range(0, 16));
            for (int w = 0; w < NUM_CH*NUM_REQ*IDX_W/32; w++) begin
                idx_i[w*32 +: 32] = $urandom;
                idx_k[w*32 +: 32] = $urandom;
            end
            for (int c = 0; c < NUM_CH; c++)
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (req[c*NUM_REQ + r]) begin
                        if (m_busy[c] != 0 && m_sel[c] == r &&
                            (m_beat[c] == m_len[c] - 1 || $urandom_range(0, 3) == 0))
                            req[c*NUM_REQ + r] = 1'b0;
                    end else if ($urandom_range(0, 5) == 0) begin
                        req[c*NUM_REQ + r] = 1'b1;
                    end
                end
            step_cycle();
        end
        req = '0;
        for (int k = 0; k < 40; k++) step_cycle();
        chk("drain_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
